// File: rtl/noc_local_injector.sv
// noc_local_injector: transmit side of the router local port.
// Turns a packet request (YX destination + payload length) and a payload
// word stream into head/body/tail flits behind a registered valid/ready slot.
// Optional build macro NOC_INJ_SEQ_EN: adds a 4-bit packet sequence counter
// carried in header bits [23:20]; without it those bits are zero.
module noc_local_injector #(
    parameter int unsigned FLIT_W      = 32,
    parameter logic [7:0]  ROUTER_ADDR = 8'h00,
    parameter int unsigned MAX_LEN     = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_dest_i,
    input  logic [3:0]        req_len_i,
    input  logic              data_valid_i,
    input  logic [FLIT_W-1:0] data_i,
    output logic              data_ready_o,
    output logic              flit_valid_o,
    output logic [FLIT_W-1:0] flit_data_o,
    output logic [1:0]        flit_type_o,
    input  logic              flit_ready_i,
    output logic              busy_o
);

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    localparam logic [1:0] TYPE_HEAD      = 2'b00;
    localparam logic [1:0] TYPE_BODY      = 2'b01;
    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    state_t            state_q, state_d;
    logic [3:0]        remaining_q, remaining_d;
    logic              slot_free;
    logic [3:0]        eff_len;
    logic [3:0]        seq_field;
    logic [FLIT_W-1:0] header;
    logic              load_en;
    logic [FLIT_W-1:0] load_data;
    logic [1:0]        load_type;

    // The slot can take a new flit when empty or when its flit leaves this cycle.
    assign slot_free = !flit_valid_o || flit_ready_i;
    assign busy_o    = (state_q != IDLE);
    assign eff_len   = (req_len_i > MAX_LEN_L) ? MAX_LEN_L : req_len_i;

`ifdef NOC_INJ_SEQ_EN
    logic [3:0] seq_q;
    logic       hdr_fire;

    assign hdr_fire  = req_valid_i && req_ready_o;
    assign seq_field = seq_q;

    // Packet sequence counter, advances once per accepted header (wraps naturally).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            seq_q <= '0;
        end else if (hdr_fire) begin
            seq_q <= seq_q + 4'd1;
        end
    end
`else
    assign seq_field = '0;
`endif

    // Header flit assembly: dest, source, clamped length, sequence; rest zero.
    always_comb begin
        header        = '0;
        header[7:0]   = req_dest_i;
        header[15:8]  = ROUTER_ADDR;
        header[19:16] = eff_len;
        header[23:20] = seq_field;
    end

    // Next-state logic, handshakes and slot load selection.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        req_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        load_en      = 1'b0;
        load_data    = header;
        load_type    = TYPE_HEAD;
        case (state_q)
            IDLE: begin
                req_ready_o = slot_free;
                if (req_valid_i && slot_free) begin
                    load_en   = 1'b1;
                    load_data = header;
                    if (eff_len == 4'd0) begin
                        load_type = TYPE_HEAD_TAIL;
                    end else begin
                        load_type   = TYPE_HEAD;
                        state_d     = BODY;
                        remaining_d = eff_len;
                    end
                end
            end
            BODY: begin
                data_ready_o = slot_free;
                if (data_valid_i && slot_free) begin
                    load_en     = 1'b1;
                    load_data   = data_i;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        load_type = TYPE_TAIL;
                        state_d   = IDLE;
                    end else begin
                        load_type = TYPE_BODY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and remaining-payload counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Output slot: load replaces contents, otherwise drains on handshake and holds on stall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flit_valid_o <= 1'b0;
            flit_data_o  <= '0;
            flit_type_o  <= '0;
        end else if (load_en) begin
            flit_valid_o <= 1'b1;
            flit_data_o  <= load_data;
            flit_type_o  <= load_type;
        end else if (flit_ready_i) begin
            flit_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// Testbench for noc_local_injector: directed and randomized packets checked
// against a queue-based model of the expected flit stream.
module tb_noc_local_injector;

    localparam int unsigned FLIT_W      = 32;
    localparam logic [7:0]  ROUTER_ADDR = 8'h00;
    localparam int unsigned MAX_LEN     = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [7:0]        req_dest = '0;
    logic [3:0]        req_len = '0;
    logic              data_valid = 1'b0;
    logic [FLIT_W-1:0] data = '0;
    logic              data_ready;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_data;
    logic [1:0]        flit_type;
    logic              flit_ready = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    noc_local_injector #(
        .FLIT_W(FLIT_W),
        .ROUTER_ADDR(ROUTER_ADDR),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_dest_i(req_dest),
        .req_len_i(req_len),
        .data_valid_i(data_valid),
        .data_i(data),
        .data_ready_o(data_ready),
        .flit_valid_o(flit_valid),
        .flit_data_o(flit_data),
        .flit_type_o(flit_type),
        .flit_ready_i(flit_ready),
        .busy_o(busy)
    );

    int checks = 0;
    int fails  = 0;

    // Model state: pending requests, core word stream, expected flits in order.
    logic [7:0]        pkt_dest_q[$];
    logic [3:0]        pkt_len_q[$];
    int                pkt_eff_q[$];
    logic [FLIT_W-1:0] word_q[$];
    logic [FLIT_W-1:0] exp_data_q[$];
    logic [1:0]        exp_type_q[$];
    int                pending = 0;
    int                seq_model = 0;
    int                cycle = 0;
    int                flit_fires = 0;
    int                first_fire = -1;
    int                last_fire = -1;
    logic              hold_prev = 1'b0;
    logic              loaded_prev = 1'b0;
    logic [FLIT_W-1:0] prev_data = '0;
    logic [1:0]        prev_type = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_packet(input logic [7:0] dest, input logic [3:0] len);
        int eff;
        int seq;
        logic [31:0] hdr;
        logic [FLIT_W-1:0] w;
        eff = (int'(len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len);
        seq = 0;
`ifdef NOC_INJ_SEQ_EN
        seq = seq_model;
        seq_model = (seq_model + 1) % 16;
`endif
        hdr = 32'(dest) + 32'(ROUTER_ADDR) * 256 + 32'(eff) * 65536 + 32'(seq) * 1048576;
        pkt_dest_q.push_back(dest);
        pkt_len_q.push_back(len);
        pkt_eff_q.push_back(eff);
        exp_data_q.push_back(FLIT_W'(hdr));
        exp_type_q.push_back((eff == 0) ? 2'b11 : 2'b00);
        for (int i = 0; i < eff; i++) begin
            w = FLIT_W'($urandom);
            word_q.push_back(w);
            exp_data_q.push_back(w);
            exp_type_q.push_back((i == eff - 1) ? 2'b10 : 2'b01);
        end
    endtask

    // One clock: drive at the falling edge, check 1 ns later, update the model.
    task automatic step(input int rp, input int dp, input int vp);
        logic req_fire;
        logic data_fire;
        @(negedge clk);
        cycle++;
        req_valid = (pkt_dest_q.size() > 0) && (int'($urandom_range(99)) < vp);
        req_dest  = (pkt_dest_q.size() > 0) ? pkt_dest_q[0] : 8'($urandom);
        req_len   = (pkt_len_q.size() > 0) ? pkt_len_q[0] : 4'($urandom);
        data_valid = (word_q.size() > 0) && (int'($urandom_range(99)) < dp);
        data       = (word_q.size() > 0) ? word_q[0] : FLIT_W'($urandom);
        flit_ready = (int'($urandom_range(99)) < rp);
        #1;
        chk("busy", 64'(busy), 64'(pending != 0));
        if (pending != 0) chk("req_ready_in_body", 64'(req_ready), 64'(0));
        else chk("data_ready_outside_body", 64'(data_ready), 64'(0));
        if (flit_valid && !flit_ready) begin
            chk("req_ready_stalled", 64'(req_ready), 64'(0));
            chk("data_ready_stalled", 64'(data_ready), 64'(0));
        end
        if (hold_prev) begin
            chk("hold_valid", 64'(flit_valid), 64'(1));
            chk("hold_data", 64'(flit_data), 64'(prev_data));
            chk("hold_type", 64'(flit_type), 64'(prev_type));
        end
        if (loaded_prev) chk("latency_valid", 64'(flit_valid), 64'(1));
        if (flit_valid && flit_ready) begin
            flit_fires++;
            last_fire = cycle;
            if (first_fire < 0) first_fire = cycle;
            chk("flit_expected", 64'(exp_data_q.size() > 0), 64'(1));
            if (exp_data_q.size() > 0) begin
                chk("flit_data", 64'(flit_data), 64'(exp_data_q.pop_front()));
                chk("flit_type", 64'(flit_type), 64'(exp_type_q.pop_front()));
            end
        end
        hold_prev   = flit_valid && !flit_ready;
        prev_data   = flit_data;
        prev_type   = flit_type;
        req_fire    = req_valid && req_ready;
        data_fire   = data_valid && data_ready;
        loaded_prev = req_fire || data_fire;
        if (req_fire) begin
            void'(pkt_dest_q.pop_front());
            void'(pkt_len_q.pop_front());
            pending = pkt_eff_q.pop_front();
        end
        if (data_fire) begin
            void'(word_q.pop_front());
            pending--;
        end
    endtask

    // Run until every queued packet has left, then idle to catch stray flits.
    task automatic run(input int rp, input int dp, input int vp, input int budget);
        int n;
        n = 0;
        while ((pkt_dest_q.size() > 0 || exp_data_q.size() > 0) && n < budget) begin
            step(rp, dp, vp);
            n++;
        end
        chk("drain_timeout", 64'(pkt_dest_q.size() + exp_data_q.size()), 64'(0));
        step(100, 100, 100);
        chk("idle_valid", 64'(flit_valid), 64'(0));
        step(100, 100, 100);
    endtask

    task automatic clear_fire_stats();
        flit_fires = 0;
        first_fire = -1;
        last_fire  = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni     = 1'b0;
        req_valid  = 1'b0;
        data_valid = 1'b0;
        flit_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_valid", 64'(flit_valid), 64'(0));
        chk("reset_data", 64'(flit_data), 64'(0));
        chk("reset_type", 64'(flit_type), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        chk("reset_data_ready", 64'(data_ready), 64'(0));
        pkt_dest_q.delete();
        pkt_len_q.delete();
        pkt_eff_q.delete();
        word_q.delete();
        exp_data_q.delete();
        exp_type_q.delete();
        pending     = 0;
        seq_model   = 0;
        hold_prev   = 1'b0;
        loaded_prev = 1'b0;
        rst_ni      = 1'b1;
    endtask

    initial begin
        int n;

        do_reset();

        // Single-flit packet.
        add_packet(8'h21, 4'd0);
        run(100, 100, 100, 50);

        // Three-word packet at full rate: four consecutive flits.
        clear_fire_stats();
        add_packet(8'h12, 4'd3);
        run(100, 100, 100, 50);
        chk("b2b_count", 64'(flit_fires), 64'(4));
        chk("b2b_span", 64'(last_fire - first_fire + 1), 64'(4));

        // Backpressure: header held for five cycles with the router stalled.
        add_packet(8'h77, 4'd2);
        for (int i = 0; i < 6; i++) step(0, 100, 100);
        run(100, 100, 100, 50);

        // Clamp: requested 15, MAX_LEN 4 -> header + 4 payload flits.
        clear_fire_stats();
        add_packet(8'h56, 4'd15);
        run(100, 100, 100, 50);
        chk("clamp_count", 64'(flit_fires), 64'(5));

        // Two packets back-to-back: next header loads as the tail leaves.
        clear_fire_stats();
        add_packet(8'h9A, 4'd3);
        add_packet(ROUTER_ADDR, 4'd2);
        run(100, 100, 100, 50);
        chk("pair_count", 64'(flit_fires), 64'(7));
        chk("pair_span", 64'(last_fire - first_fire + 1), 64'(7));

        // Randomized packets and handshake timing.
        for (int p = 0; p < 40; p++) add_packet(8'($urandom), 4'($urandom_range(15)));
        run(70, 70, 80, 3000);

        // Reset after the first body flit of a three-word packet.
        clear_fire_stats();
        add_packet(8'h33, 4'd3);
        n = 0;
        while (flit_fires < 2 && n < 50) begin
            step(100, 100, 100);
            n++;
        end
        chk("midpkt_reached", 64'(flit_fires >= 2), 64'(1));
        do_reset();
        add_packet(8'h44, 4'd0);
        run(100, 100, 100, 50);

        // Sequence field over 17 single-flit packets (zero when the counter is not built).
        do_reset();
        for (int p = 0; p < 17; p++) add_packet(8'($urandom), 4'd0);
        run(100, 100, 100, 200);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
